// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C transaction sequencer: core byte-ops, FSM states, error codes.
package i2c_seq_pkg;

    typedef enum logic [2:0] {
        OpStart   = 3'd0,
        OpRestart = 3'd1,
        OpWrite   = 3'd2,
        OpRead    = 3'd3,
        OpStop    = 3'd4
    } core_op_e;

    typedef enum logic [3:0] {
        StIdle,
        StStart,
        StAddrW,
        StReg,
        StWdata,
        StRestart,
        StAddrR,
        StRdata,
        StRdHold,
        StStop,
        StFinish
    } state_e;

    localparam logic [1:0] ErrNone     = 2'd0;
    localparam logic [1:0] ErrAddrNack = 2'd1;
    localparam logic [1:0] ErrDataNack = 2'd2;
    localparam logic [1:0] ErrTimeout  = 2'd3;

endpackage

// File: rtl/i2c_seq_timer.sv
// Per-op watchdog for the I2C sequencer; only instantiated when I2C_SEQ_TIMEOUT_EN is defined.
module i2c_seq_timer #(
    parameter int unsigned TIMEOUT_CYC = 60000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0] Reload = CntW'(TIMEOUT_CYC - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = Reload;
        end else if (run && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The load cycle counts as the first cycle of the budget.
    assign expired = run && !load && (cnt_q == '0);

endmodule

// File: rtl/i2c_txn_sequencer.sv
// Register-level I2C transaction sequencer driving a byte-op master core.
// Optional per-op watchdog enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_txn_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 60000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr7,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_len,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic [2:0] core_op,
    output logic       core_op_valid,
    output logic [7:0] core_tx,
    output logic       core_mnack,
    input  logic       core_done,
    input  logic [7:0] core_rx,
    input  logic       core_sack,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    state_e     state_q, state_d;
    logic       issued_q, issued_d;
    logic       rw_q, rw_d;
    logic [6:0] addr_q, addr_d;
    logic [7:0] reg_q, reg_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] code_q, code_d;
    logic       op_valid_q, op_valid_d;
    core_op_e   op_q, op_d;
    logic [7:0] tx_q, tx_d;
    logic       mnack_q, mnack_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       tmo_q, tmo_d;

    logic       want_issue;
    core_op_e   want_op;
    logic [7:0] want_tx;
    logic       want_mn;
    logic       op_done;
    logic       tmo_expired;

    assign op_done = issued_q && core_done;

`ifdef I2C_SEQ_TIMEOUT_EN
    i2c_seq_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (op_valid_q),
        .run    (issued_q && !core_done),
        .expired(tmo_expired)
    );
`else
    // Without the watchdog the block waits on core_done forever.
    assign tmo_expired = (TIMEOUT_CYC == 32'd0) && 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        issued_d   = issued_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        reg_d      = reg_q;
        cnt_d      = cnt_q;
        code_d     = code_q;
        op_valid_d = 1'b0;
        op_d       = op_q;
        tx_d       = tx_q;
        mnack_d    = mnack_q;
        rd_data_d  = rd_data_q;
        tmo_d      = 1'b0;
        want_issue = 1'b0;
        want_op    = OpStart;
        want_tx    = tx_q;
        want_mn    = 1'b0;
        cmd_ready  = 1'b0;
        wr_ready   = 1'b0;

        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                issued_d  = 1'b0;
                if (cmd_valid) begin
                    rw_d    = cmd_rw;
                    addr_d  = cmd_addr7;
                    reg_d   = cmd_reg;
                    cnt_d   = cmd_len;
                    code_d  = ErrNone;
                    state_d = StStart;
                end
            end
            StStart: begin
                want_issue = 1'b1;
                want_op    = OpStart;
                if (op_done) state_d = StAddrW;
            end
            StAddrW: begin
                want_issue = 1'b1;
                want_op    = OpWrite;
                want_tx    = {addr_q, 1'b0};
                if (op_done) begin
                    if (core_sack) begin
                        code_d  = ErrAddrNack;
                        state_d = StStop;
                    end else begin
                        state_d = StReg;
                    end
                end
            end
            StReg: begin
                want_issue = 1'b1;
                want_op    = OpWrite;
                want_tx    = reg_q;
                if (op_done) begin
                    if (core_sack) begin
                        code_d  = ErrDataNack;
                        state_d = StStop;
                    end else if (cnt_q == 8'd0) begin
                        state_d = StStop;
                    end else begin
                        state_d = rw_q ? StRestart : StWdata;
                    end
                end
            end
            StWdata: begin
                // The op waits for a payload byte; wr_ready marks the cycle it is captured.
                want_issue = wr_valid;
                want_op    = OpWrite;
                want_tx    = wr_data;
                wr_ready   = !issued_q && wr_valid;
                if (op_done) begin
                    cnt_d = cnt_q - 8'd1;
                    if (core_sack) begin
                        code_d  = ErrDataNack;
                        state_d = StStop;
                    end else if (cnt_q == 8'd1) begin
                        state_d = StStop;
                    end
                end
            end
            StRestart: begin
                want_issue = 1'b1;
                want_op    = OpRestart;
                if (op_done) state_d = StAddrR;
            end
            StAddrR: begin
                want_issue = 1'b1;
                want_op    = OpWrite;
                want_tx    = {addr_q, 1'b1};
                if (op_done) begin
                    if (core_sack) begin
                        code_d  = ErrAddrNack;
                        state_d = StStop;
                    end else begin
                        state_d = StRdata;
                    end
                end
            end
            StRdata: begin
                want_issue = 1'b1;
                want_op    = OpRead;
                want_mn    = (cnt_q == 8'd1);
                if (op_done) begin
                    rd_data_d = core_rx;
                    cnt_d     = cnt_q - 8'd1;
                    state_d   = StRdHold;
                end
            end
            StRdHold: begin
                if (rd_ready) state_d = (cnt_q == 8'd0) ? StStop : StRdata;
            end
            StStop: begin
                want_issue = 1'b1;
                want_op    = OpStop;
                if (op_done) state_d = StFinish;
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (want_issue && !issued_q) begin
            op_valid_d = 1'b1;
            op_d       = want_op;
            tx_d       = want_tx;
            mnack_d    = want_mn;
            issued_d   = 1'b1;
        end
        if (op_done) issued_d = 1'b0;

        // A stuck core abandons the transfer outright; STOP would just hang too.
        if (tmo_expired) begin
            state_d    = StIdle;
            issued_d   = 1'b0;
            op_valid_d = 1'b0;
            tmo_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            issued_q   <= 1'b0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            reg_q      <= '0;
            cnt_q      <= '0;
            code_q     <= ErrNone;
            op_valid_q <= 1'b0;
            op_q       <= OpStart;
            tx_q       <= '0;
            mnack_q    <= 1'b0;
            rd_data_q  <= '0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            reg_q      <= reg_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            op_valid_q <= op_valid_d;
            op_q       <= op_d;
            tx_q       <= tx_d;
            mnack_q    <= mnack_d;
            rd_data_q  <= rd_data_d;
            tmo_q      <= tmo_d;
        end
    end

    assign busy          = (state_q != StIdle);
    assign rd_valid      = (state_q == StRdHold);
    assign rd_data       = rd_data_q;
    assign core_op       = op_q;
    assign core_op_valid = op_valid_q;
    assign core_tx       = tx_q;
    assign core_mnack    = mnack_q;
    assign done          = (state_q == StFinish) && (code_q == ErrNone);
    assign err           = ((state_q == StFinish) && (code_q != ErrNone)) || tmo_q;
    assign err_code      = tmo_q ? ErrTimeout : ((state_q == StFinish) ? code_q : ErrNone);

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Scoreboard bench for i2c_txn_sequencer with a behavioural byte-op core.
module tb_i2c_txn_sequencer;
    import i2c_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_rw;
    logic [6:0] cmd_addr7;
    logic [7:0] cmd_reg, cmd_len;
    logic [7:0] wr_data;
    logic       wr_valid, wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid, rd_ready;
    logic [2:0] core_op;
    logic       core_op_valid;
    logic [7:0] core_tx;
    logic       core_mnack;
    logic       core_done;
    logic [7:0] core_rx;
    logic       core_sack;
    logic       busy, done, err;
    logic [1:0] err_code;

    i2c_txn_sequencer #(
        .TIMEOUT_CYC(100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_rw       (cmd_rw),
        .cmd_addr7    (cmd_addr7),
        .cmd_reg      (cmd_reg),
        .cmd_len      (cmd_len),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .core_op      (core_op),
        .core_op_valid(core_op_valid),
        .core_tx      (core_tx),
        .core_mnack   (core_mnack),
        .core_done    (core_done),
        .core_rx      (core_rx),
        .core_sack    (core_sack),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .err_code     (err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] tx;
        logic       mn;
    } op_t;

    op_t        exp_ops[$];
    logic [7:0] slave_q[$];
    logic [7:0] exp_rd[$];

    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         op_cnt = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         wr_take_cnt = 0;
    int         rd_cnt = 0;
    logic [1:0] last_code = 2'd0;
    int         nack_write_n = 0;
    bit         withhold = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural core: checks each op against the scoreboard, answers 3 cycles later.
    initial begin : core_model
        int  wr_seen;
        op_t got;
        op_t e;
        core_done = 1'b0;
        core_sack = 1'b0;
        core_rx   = 8'h00;
        wr_seen   = 0;
        forever begin
            @(negedge clk);
            if (core_op_valid === 1'b1 && rst === 1'b0) begin
                got.op = core_op;
                got.tx = core_tx;
                got.mn = core_mnack;
                op_cnt++;
                n_cmp++;
                if (exp_ops.size() == 0) begin
                    n_fail++;
                    $display("FAIL op_unexpected: got op=%0d tx=%h mnack=%b, required no op",
                             got.op, got.tx, got.mn);
                end else begin
                    e = exp_ops.pop_front();
                    if (got.op !== e.op || (e.op == OpWrite && got.tx !== e.tx) ||
                        (e.op == OpRead && got.mn !== e.mn)) begin
                        n_fail++;
                        $display("FAIL op_seq: got op=%0d tx=%h mnack=%b, required op=%0d tx=%h mnack=%b",
                                 got.op, got.tx, got.mn, e.op, e.tx, e.mn);
                    end
                end
                if (got.op == OpStart) wr_seen = 0;
                if (got.op == OpWrite) wr_seen++;
                repeat (2) @(posedge clk);
                #1;
                if (!withhold) begin
                    core_sack = (got.op == OpWrite) && (wr_seen == nack_write_n);
                    if (got.op == OpRead) core_rx = (slave_q.size() > 0) ? slave_q.pop_front() : 8'h00;
                    core_done = 1'b1;
                    @(posedge clk);
                    #1;
                    core_done = 1'b0;
                    core_sack = 1'b0;
                end
            end
        end
    end

    initial begin : status_mon
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                if (done === 1'b1) done_cnt++;
                if (err === 1'b1) begin
                    err_cnt++;
                    last_code = err_code;
                end
                if (wr_ready === 1'b1) wr_take_cnt++;
                if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
                    rd_cnt++;
                    n_cmp++;
                    if (exp_rd.size() == 0) begin
                        n_fail++;
                        $display("FAIL rd_unexpected: got rd_data=%h, required no read byte", rd_data);
                    end else begin
                        e = exp_rd.pop_front();
                        if (rd_data !== e) begin
                            n_fail++;
                            $display("FAIL rd_data: got %h, required %h", rd_data, e);
                        end
                    end
                end
            end
        end
    end

    task automatic push_op(input logic [2:0] op, input logic [7:0] tx, input logic mn);
        op_t o;
        o.op = op;
        o.tx = tx;
        o.mn = mn;
        exp_ops.push_back(o);
    endtask

    task automatic send_cmd(input logic rw, input logic [6:0] a, input logic [7:0] r,
                            input logic [7:0] len);
        int t = 0;
        while (cmd_ready !== 1'b1 && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        cmd_rw    = rw;
        cmd_addr7 = a;
        cmd_reg   = r;
        cmd_len   = len;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        // Scramble fields so any failure to latch them shows up in the op stream.
        cmd_rw    = ~rw;
        cmd_addr7 = 7'h7F;
        cmd_reg   = 8'h00;
        cmd_len   = 8'hFF;
    endtask

    task automatic feed(input logic [7:0] b);
        int t = 0;
        wr_data  = b;
        wr_valid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (wr_ready !== 1'b1 && t < 500);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int bound, output bit timed_out);
        int t = 0;
        @(posedge clk);
        #1;
        while (busy !== 1'b0 && t < bound) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        timed_out = (t >= bound);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({cmd_ready, wr_ready, rd_valid, core_op_valid, busy, done, err} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy/wrr/rdv/opv/busy/done/err=%b, required 1000000",
                     {cmd_ready, wr_ready, rd_valid, core_op_valid, busy, done, err});
        end
        n_cmp++;
        if ({err_code, core_tx, rd_data} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_data: got err_code=%0d core_tx=%h rd_data=%h, required 0/00/00",
                     err_code, core_tx, rd_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || core_op_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got cmd_ready=%b busy=%b op_valid=%b, required 1/0/0",
                     cmd_ready, busy, core_op_valid);
        end
    endtask

    task automatic test_write();
        int d0 = done_cnt;
        int e0 = err_cnt;
        int w0 = wr_take_cnt;
        bit to;
        push_op(OpStart, 8'h00, 1'b0);
        push_op(OpWrite, 8'hA0, 1'b0);
        push_op(OpWrite, 8'hAA, 1'b0);
        push_op(OpWrite, 8'h12, 1'b0);
        push_op(OpWrite, 8'h34, 1'b0);
        push_op(OpStop, 8'h00, 1'b0);
        // Payload offered before the command: must not be taken outside WDATA.
        wr_data  = 8'h12;
        wr_valid = 1'b1;
        send_cmd(1'b0, 7'h50, 8'hAA, 8'd2);
        feed(8'h12);
        feed(8'h34);
        wr_valid = 1'b0;
        wait_idle(2000, to);
        n_cmp++;
        if (to || done_cnt - d0 != 1 || err_cnt != e0) begin
            n_fail++;
            $display("FAIL write_status: got timeout=%b done=%0d err=%0d, required 0/1/0",
                     to, done_cnt - d0, err_cnt - e0);
        end
        n_cmp++;
        if (wr_take_cnt - w0 != 2 || exp_ops.size() != 0) begin
            n_fail++;
            $display("FAIL write_ops: got bytes_taken=%0d ops_left=%0d, required 2/0",
                     wr_take_cnt - w0, exp_ops.size());
        end
    endtask

    task automatic test_read();
        int d0 = done_cnt;
        int r0 = rd_cnt;
        bit to;
        logic [7:0] bytes[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        push_op(OpStart, 8'h00, 1'b0);
        push_op(OpWrite, 8'hA0, 1'b0);
        push_op(OpWrite, 8'hBB, 1'b0);
        push_op(OpRestart, 8'h00, 1'b0);
        push_op(OpWrite, 8'hA1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            push_op(OpRead, 8'h00, (i == 3));
            slave_q.push_back(bytes[i]);
            exp_rd.push_back(bytes[i]);
        end
        push_op(OpStop, 8'h00, 1'b0);
        rd_ready = 1'b1;
        send_cmd(1'b1, 7'h50, 8'hBB, 8'd4);
        wait_idle(2000, to);
        n_cmp++;
        if (to || done_cnt - d0 != 1 || rd_cnt - r0 != 4) begin
            n_fail++;
            $display("FAIL read_status: got timeout=%b done=%0d bytes=%0d, required 0/1/4",
                     to, done_cnt - d0, rd_cnt - r0);
        end
        n_cmp++;
        if (exp_ops.size() != 0 || exp_rd.size() != 0) begin
            n_fail++;
            $display("FAIL read_drain: got ops_left=%0d rd_left=%0d, required 0/0",
                     exp_ops.size(), exp_rd.size());
        end
    endtask

    task automatic test_read_zero();
        int d0 = done_cnt;
        int r0 = rd_cnt;
        bit to;
        push_op(OpStart, 8'h00, 1'b0);
        push_op(OpWrite, 8'hA0, 1'b0);
        push_op(OpWrite, 8'h33, 1'b0);
        push_op(OpStop, 8'h00, 1'b0);
        send_cmd(1'b1, 7'h50, 8'h33, 8'd0);
        wait_idle(2000, to);
        n_cmp++;
        if (to || done_cnt - d0 != 1 || rd_cnt != r0 || exp_ops.size() != 0) begin
            n_fail++;
            $display("FAIL read_zero: got timeout=%b done=%0d bytes=%0d ops_left=%0d, required 0/1/0/0",
                     to, done_cnt - d0, rd_cnt - r0, exp_ops.size());
        end
    endtask

    task automatic test_addr_nack();
        int d0 = done_cnt;
        int e0 = err_cnt;
        int w0 = wr_take_cnt;
        bit to;
        nack_write_n = 1;
        push_op(OpStart, 8'h00, 1'b0);
        push_op(OpWrite, 8'hA2, 1'b0);
        push_op(OpStop, 8'h00, 1'b0);
        wr_data  = 8'h55;
        wr_valid = 1'b1;
        send_cmd(1'b0, 7'h51, 8'hAA, 8'd2);
        wait_idle(2000, to);
        wr_valid     = 1'b0;
        nack_write_n = 0;
        n_cmp++;
        if (to || err_cnt - e0 != 1 || last_code !== ErrAddrNack || done_cnt != d0) begin
            n_fail++;
            $display("FAIL addr_nack: got timeout=%b err=%0d code=%0d done=%0d, required 0/1/1/0",
                     to, err_cnt - e0, last_code, done_cnt - d0);
        end
        n_cmp++;
        if (wr_take_cnt != w0 || exp_ops.size() != 0) begin
            n_fail++;
            $display("FAIL addr_nack_payload: got bytes_taken=%0d ops_left=%0d, required 0/0",
                     wr_take_cnt - w0, exp_ops.size());
        end
    endtask

    task automatic test_data_nack();
        int e0 = err_cnt;
        int w0 = wr_take_cnt;
        bit to;
        nack_write_n = 3;
        push_op(OpStart, 8'h00, 1'b0);
        push_op(OpWrite, 8'h44, 1'b0);
        push_op(OpWrite, 8'h10, 1'b0);
        push_op(OpWrite, 8'h77, 1'b0);
        push_op(OpStop, 8'h00, 1'b0);
        send_cmd(1'b0, 7'h22, 8'h10, 8'd2);
        feed(8'h77);
        wr_data = 8'h88;
        wait_idle(2000, to);
        wr_valid     = 1'b0;
        nack_write_n = 0;
        n_cmp++;
        if (to || err_cnt - e0 != 1 || last_code !== ErrDataNack || wr_take_cnt - w0 != 1 ||
            exp_ops.size() != 0) begin
            n_fail++;
            $display("FAIL data_nack: got timeout=%b err=%0d code=%0d taken=%0d ops_left=%0d, required 0/1/2/1/0",
                     to, err_cnt - e0, last_code, wr_take_cnt - w0, exp_ops.size());
        end
    endtask

    task automatic test_backpressure();
        int d0 = done_cnt;
        int t = 0;
        int o0;
        int bad = 0;
        bit to;
        push_op(OpStart, 8'h00, 1'b0);
        push_op(OpWrite, 8'hA0, 1'b0);
        push_op(OpWrite, 8'h01, 1'b0);
        push_op(OpRestart, 8'h00, 1'b0);
        push_op(OpWrite, 8'hA1, 1'b0);
        push_op(OpRead, 8'h00, 1'b0);
        push_op(OpRead, 8'h00, 1'b1);
        push_op(OpStop, 8'h00, 1'b0);
        slave_q.push_back(8'hDE);
        slave_q.push_back(8'h99);
        exp_rd.push_back(8'hDE);
        exp_rd.push_back(8'h99);
        rd_ready = 1'b0;
        send_cmd(1'b1, 7'h50, 8'h01, 8'd2);
        while (rd_valid !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t >= 500) begin
            n_fail++;
            $display("FAIL bp_rd_valid: got no rd_valid in 500 cycles, required rd_valid=1");
        end
        @(posedge clk);
        #1;
        o0 = op_cnt;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rd_valid !== 1'b1 || rd_data !== 8'hDE) bad++;
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (bad != 0 || op_cnt != o0) begin
            n_fail++;
            $display("FAIL bp_hold: got bad_cycles=%0d ops_during_hold=%0d, required 0/0",
                     bad, op_cnt - o0);
        end
        rd_ready = 1'b1;
        wait_idle(2000, to);
        n_cmp++;
        if (to || done_cnt - d0 != 1 || exp_ops.size() != 0 || exp_rd.size() != 0) begin
            n_fail++;
            $display("FAIL bp_finish: got timeout=%b done=%0d ops_left=%0d rd_left=%0d, required 0/1/0/0",
                     to, done_cnt - d0, exp_ops.size(), exp_rd.size());
        end
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        int t = 0;
        bit rdy;
        bit to;
        for (int k = 0; k < 2; k++) begin
            push_op(OpStart, 8'h00, 1'b0);
            push_op(OpWrite, (k == 0) ? 8'h20 : 8'h30, 1'b0);
            push_op(OpWrite, (k == 0) ? 8'h01 : 8'h02, 1'b0);
            push_op(OpStop, 8'h00, 1'b0);
        end
        send_cmd(1'b0, 7'h10, 8'h01, 8'd0);
        // Second command held valid while busy; it must wait for IDLE.
        cmd_rw    = 1'b0;
        cmd_addr7 = 7'h18;
        cmd_reg   = 8'h02;
        cmd_len   = 8'd0;
        cmd_valid = 1'b1;
        do begin
            @(negedge clk);
            rdy = cmd_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!rdy && t < 1000);
        cmd_valid = 1'b0;
        wait_idle(2000, to);
        n_cmp++;
        if (to || done_cnt - d0 != 2 || exp_ops.size() != 0) begin
            n_fail++;
            $display("FAIL back_to_back: got timeout=%b done=%0d ops_left=%0d, required 0/2/0",
                     to, done_cnt - d0, exp_ops.size());
        end
    endtask

    task automatic test_reset_mid();
        int o0 = op_cnt;
        int d0;
        int t = 0;
        bit to;
        push_op(OpStart, 8'h00, 1'b0);
        push_op(OpWrite, 8'hA0, 1'b0);
        push_op(OpWrite, 8'h5A, 1'b0);
        wr_valid = 1'b0;
        send_cmd(1'b0, 7'h50, 8'h5A, 8'd2);
        while (op_cnt < o0 + 3 && t < 500) begin
            @(posedge clk);
            t++;
        end
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({cmd_ready, wr_ready, rd_valid, core_op_valid, busy, done, err} !== 7'b1000000 ||
            {err_code, core_tx, rd_data} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got ctrl=%b err_code=%0d core_tx=%h rd_data=%h, required 1000000/0/00/00",
                     {cmd_ready, wr_ready, rd_valid, core_op_valid, busy, done, err},
                     err_code, core_tx, rd_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (exp_ops.size() != 0 || op_cnt != o0 + 3) begin
            n_fail++;
            $display("FAIL reset_no_stop: got ops_left=%0d ops_issued=%0d, required 0/3",
                     exp_ops.size(), op_cnt - o0);
        end
        d0 = done_cnt;
        push_op(OpStart, 8'h00, 1'b0);
        push_op(OpWrite, 8'hA0, 1'b0);
        push_op(OpWrite, 8'h5A, 1'b0);
        push_op(OpWrite, 8'hC3, 1'b0);
        push_op(OpStop, 8'h00, 1'b0);
        send_cmd(1'b0, 7'h50, 8'h5A, 8'd1);
        feed(8'hC3);
        wr_valid = 1'b0;
        wait_idle(2000, to);
        n_cmp++;
        if (to || done_cnt - d0 != 1 || exp_ops.size() != 0) begin
            n_fail++;
            $display("FAIL write_after_reset: got timeout=%b done=%0d ops_left=%0d, required 0/1/0",
                     to, done_cnt - d0, exp_ops.size());
        end
    endtask

`ifdef I2C_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int o0 = op_cnt;
        int e0 = err_cnt;
        int t = 0;
        int t_op;
        int t_err;
        withhold = 1'b1;
        push_op(OpStart, 8'h00, 1'b0);
        send_cmd(1'b0, 7'h50, 8'hAA, 8'd1);
        while (op_cnt == o0 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        t_op = cyc;
        t = 0;
        while (err_cnt == e0 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        t_err = cyc;
        n_cmp++;
        if (err_cnt == e0 || last_code !== ErrTimeout || t_err - t_op < 95 || t_err - t_op > 106) begin
            n_fail++;
            $display("FAIL timeout_err: got err=%0d code=%0d latency=%0d, required 1/3/~101",
                     err_cnt - e0, last_code, t_err - t_op);
        end
        n_cmp++;
        if (busy !== 1'b0 || exp_ops.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_idle: got busy=%b ops_left=%0d, required 0/0", busy, exp_ops.size());
        end
        withhold = 1'b0;
    endtask
`else
    task automatic test_no_timeout();
        int e0 = err_cnt;
        withhold = 1'b1;
        push_op(OpStart, 8'h00, 1'b0);
        send_cmd(1'b0, 7'h50, 8'hAA, 8'd1);
        repeat (300) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b1 || err_cnt != e0 || exp_ops.size() != 0) begin
            n_fail++;
            $display("FAIL no_timeout: got busy=%b err=%0d ops_left=%0d, required 1/0/0",
                     busy, err_cnt - e0, exp_ops.size());
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        withhold = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL no_timeout_reset: got busy=%b cmd_ready=%b, required 0/1", busy, cmd_ready);
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_rw    = 1'b0;
        cmd_addr7 = 7'h00;
        cmd_reg   = 8'h00;
        cmd_len   = 8'h00;
        wr_data   = 8'h00;
        wr_valid  = 1'b0;
        rd_ready  = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_read_zero();
        test_addr_nack();
        test_data_nack();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef I2C_SEQ_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
